sar_adc_ctrl: RTL and testbench

Successive-approximation ADC stage directly downstream of the differential sample-and-hold. It watches the S&H `hold` phase, lets the held differential voltage settle, then resolves it MSB-first against an ideal real-valued binary DAC with a real comparator model. It delivers an `NBITS` offset-binary code with a one-cycle `valid` strobe. Analog pins are `wreal4state`; control is clocked by a single clock.

---
 rtl/sar_adc_ctrl.sv | 135 +++++++++++++
 tb/tb_sar_adc_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: SAR conversion controller with ideal real-valued DAC and comparator model.
// Optional macro SAR_CMP_NOISE_EN adds comparator noise; undriven/invalid analog pins arrive as NaN.
`default_nettype none

module sar_adc_ctrl #(
  parameter int  NBITS      = 10,
  parameter int  SETTLE_CYC = 2,
  parameter real COMP_OFS   = 0.0,
  parameter real CMP_NS_STD = 1.0e-6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold,
  input  real              inp,
  input  real              inm,
  input  real              vref,
  output logic [NBITS-1:0] code,
  output logic             valid,
  output logic             busy,
  output logic             ovr
);

  localparam int  CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int  BW = $clog2(NBITS);
  localparam real FS = real'(1 << NBITS);
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, CONV, DONE} state_t;

  state_t           state, state_nx;
  logic             hold_q, start;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    idx;
  logic [NBITS-1:0] result, trial, decided;
  logic             ovr_pend, bad_pend;
  logic             in_bad, in_ovr, keep;
  real              vdiff, vth, noise;

  // NaN and +/-inf both fail this test, which covers a high-impedance pin.
  function automatic logic finite(input real x);
    return (x - x) == 0.0;
  endfunction

`ifdef SAR_CMP_NOISE_EN
  integer seed = 789;
  always_ff @(posedge clk) noise <= CMP_NS_STD * real'($dist_normal(seed, 0, 1));
`else
  assign noise = 0.0 * CMP_NS_STD;
`endif

  always_comb begin
    vdiff   = inp - inm;
    trial   = result | (ONE << idx);
    vth     = vref * (2.0 * real'(trial) / FS - 1.0) + COMP_OFS;
    keep    = (vdiff + noise) >= vth;
    decided = keep ? trial : result;
    in_bad  = !finite(inp) || !finite(inm) || !finite(vref);
    in_ovr  = (vdiff > vref) || (vdiff < -vref);
    start   = hold && !hold_q && en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = SETTLE;
      SETTLE: if (!en) state_nx = IDLE;
              else if (cnt == '0) state_nx = CONV;
      CONV:   if (!en) state_nx = IDLE;
              else if (idx == '0) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q   <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      result   <= '0;
      ovr_pend <= 1'b0;
      bad_pend <= 1'b0;
      code     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      hold_q <= hold;
      valid  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          cnt  <= CW'(SETTLE_CYC - 1);
        end
        SETTLE: begin
          if (!en) busy <= 1'b0;
          else if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            idx    <= BW'(NBITS - 1);
            result <= '0;
          end
        end
        CONV: begin
          if (!en) busy <= 1'b0;
          else begin
            result <= decided;
            // Range/validity is judged once, on the MSB decision.
            if (idx == BW'(NBITS - 1)) begin
              ovr_pend <= in_ovr || in_bad;
              bad_pend <= in_bad;
            end
            if (idx == '0) begin
              code  <= bad_pend ? '0 : decided;
              ovr   <= ovr_pend;
              valid <= 1'b1;
            end else begin
              idx <= idx - BW'(1);
            end
          end
        end
        DONE: busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed plus randomized conversions checked against an ideal quantizer model.
`default_nettype none

module tb_sar_adc_ctrl;
  localparam int NBITS = 10;
  localparam int SETTLE = 2;
  localparam int LAT = SETTLE + NBITS;
  localparam real OFS2 = 0.01;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, hold = 1'b0;
  real inp = 0.0, inm = 0.0, vref = 1.0;
  logic [NBITS-1:0] code, code_o;
  logic valid, busy, ovr, valid_o, busy_o, ovr_o;
  int checks = 0, errors = 0;
  int last_code = 0;
  logic last_ovr = 1'b0;

  always #5 clk = ~clk;

  sar_adc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .inp(inp), .inm(inm), .vref(vref),
    .code(code), .valid(valid), .busy(busy), .ovr(ovr));

  sar_adc_ctrl #(.COMP_OFS(OFS2)) dut_o (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .inp(inp), .inm(inm), .vref(vref),
    .code(code_o), .valid(valid_o), .busy(busy_o), .ovr(ovr_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic real nan_val();
    return $bitstoreal(64'h7FF8_0000_0000_0000);
  endfunction

  function automatic bit is_fin(input real x);
    return (x - x) == 0.0;
  endfunction

  // Ideal quantizer: code = floor((vdiff - ofs)/vref * 2^(N-1) + 2^(N-1)), clamped.
  function automatic int model_code(input real vp, input real vm, input real vr, input real ofs);
    real x;
    if (!is_fin(vp) || !is_fin(vm) || !is_fin(vr)) return 0;
    x = (vp - vm - ofs) / vr * 512.0 + 512.0;
    if (x < 0.0) return 0;
    if (x >= 1024.0) return 1023;
    return $rtoi($floor(x));
  endfunction

  function automatic bit model_ovr(input real vp, input real vm, input real vr);
    real d;
    if (!is_fin(vp) || !is_fin(vm) || !is_fin(vr)) return 1'b1;
    d = vp - vm;
    return (d > vr) || (d < -vr);
  endfunction

  task automatic convert(input real vp, input real vm, input bit glitch, input string tag);
    int first_k, nvalid, ec, eco;
    logic eo, busy_lat, busy_aft;
    ec  = model_code(vp, vm, vref, 0.0);
    eco = model_code(vp, vm, vref, OFS2);
    eo  = model_ovr(vp, vm, vref);
    first_k = 0; nvalid = 0; busy_lat = 1'bx; busy_aft = 1'bx;
    @(negedge clk);
    inp = vp; inm = vm; hold = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("%s busy_e0", tag), busy, 1);
    for (int k = 1; k <= 2 * LAT + 4; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        if (first_k == 0) first_k = k;
        nvalid++;
      end
      if (k == LAT) busy_lat = busy;
      if (k == LAT + 1) busy_aft = busy;
      if (k == 2) hold = 1'b0;
      if (glitch && k == 5) hold = 1'b1;
      if (glitch && k == 7) hold = 1'b0;
    end
    chk($sformatf("%s latency", tag), first_k, LAT);
    chk($sformatf("%s nvalid", tag), nvalid, 1);
    chk($sformatf("%s busy_last", tag), busy_lat, 1);
    chk($sformatf("%s busy_after", tag), busy_aft, 0);
    chk($sformatf("%s code", tag), code, ec);
    chk($sformatf("%s ovr", tag), ovr, eo);
    chk($sformatf("%s code_ofs", tag), code_o, eco);
    chk($sformatf("%s ovr_ofs", tag), ovr_o, eo);
    last_code = ec;
    last_ovr = eo;
  endtask

  initial begin
    int r, kc, nvalid;
    real d, vcm;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst code", code, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    chk("rst ovr", ovr, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed values
    convert(0.9, 0.9, 1'b0, "mid");
    chk("mid exact", code, 512);
    convert(0.5, 0.0, 1'b0, "p05");
    chk("p05 exact", code, 768);
    convert(0.3, 0.0, 1'b0, "p03");
    chk("p03 exact", code, 665);
    convert(0.0, 1.0, 1'b0, "neg_fs");
    chk("neg_fs exact", code, 0);
    convert(1.2, 0.0, 1'b0, "over");
    chk("over code", code, 1023);
    chk("over flag", ovr, 1);
    convert(nan_val(), 0.0, 1'b0, "hiz");
    chk("hiz code", code, 0);
    chk("hiz flag", ovr, 1);

    // Randomized conversions at code-bin centres, plus out-of-range picks
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0: vref = 0.5;
        1: vref = 1.0;
        default: vref = 2.0;
      endcase
      if (r < 2) begin
        d = vref * (1.05 + real'($urandom_range(0, 400)) / 1000.0);
        if (r == 1) d = -d;
      end else begin
        kc = $urandom_range(0, 1023);
        d = vref * (real'(2 * kc + 1) / 1024.0 - 1.0);
      end
      vcm = real'($urandom_range(0, 1000)) / 1000.0;
      convert(vcm + d / 2.0, vcm - d / 2.0, 1'b0, $sformatf("rnd%0d", i));
    end
    vref = 1.0;

    // Second hold rise during CONV must not queue a conversion
    convert(0.25, 0.0, 1'b1, "glitch");

    // Enable dropped on the third CONV edge: abort, keep previous result
    @(negedge clk);
    inp = -0.5; inm = 0.0; hold = 1'b1;
    @(posedge clk); #1;
    nvalid = 0;
    for (int k = 1; k <= 2 * LAT; k++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
      if (k == 2) hold = 1'b0;
      if (k == 4) en = 1'b0;
      if (k == 5) chk("en_drop busy", busy, 0);
    end
    chk("en_drop nvalid", nvalid, 0);
    chk("en_drop code", code, last_code);
    chk("en_drop ovr", ovr, last_ovr);
    @(negedge clk); en = 1'b1;

    // Reset pulse mid-CONV clears everything at that edge
    @(negedge clk);
    inp = 0.3; inm = 0.0; hold = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) hold = 1'b0;
      if (k == 5) rst_n = 1'b0;
      if (k == 6) begin
        chk("midrst busy", busy, 0);
        chk("midrst valid", valid, 0);
        chk("midrst code", code, 0);
        chk("midrst ovr", ovr, 0);
        rst_n = 1'b1;
      end
    end
    repeat (2) @(posedge clk);
    convert(0.9, 0.9, 1'b0, "post_rst");
    chk("post_rst ofs exact", code_o, 506);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
